uba_dma_master: RTL and testbench
=================================

# uba_dma_master

Bus-master sequencer for the Unibus Adapter DMA (NPR) path. It accepts one device transfer request at a time, checks the page-translation result for that request, and issues KS10 backplane read or write cycles on the physical address. It performs read-pause-write merges for halfword writes and forced-RPW pages, then returns data, acknowledge or non-existent-memory status to the requesting device. It sits between the UBA device arbiter and the KS10 bus arbiter, alongside the UBA paging RAM.

## Interface
- `TIMEOUT`, default 63: number of cycles `busACKI` may stay low during a bus request before NXM is declared; range 1–255.

Ports:
- `clk` in 1: clock; all logic is on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `devREQI` in 1: device transfer request; level, held until `devACKO` or `devNXMO`.
- `devADDRI` in 36: device address. Bit 3 is read, bit 5 is write, bits 19:24 are the virtual page, bit 34 is the halfword select (W); flags are placed here by the device.
- `devDATAI` in 36: device write data; the halfword to write is in the half selected by W.
- `devDATAO` out 36: read data to the device, registered.
- `devACKO` out 1: one-cycle transfer-complete pulse.
- `devNXMO` out 1: one-cycle failure pulse.
- `pageADDRI` in 36: translated bus address from the pager (combinational, same cycle as `devADDRI`).
- `pageNXMI` in 1: pager failure (invalid page or A17 set).
- `pageFLGI` in 3: {RPW, E16, FTM} for the current virtual page.
- `busREQO` out 1: KS10 bus request.
- `busACKI` in 1: KS10 bus acknowledge; read data is valid in the same cycle.
- `busADDRO` out 36: bus address, registered. Flags are rewritten by this block: bit 3 is read, bit 5 is write.
- `busDATAO` out 36: bus write data, registered.
- `busDATAI` in 36: bus read data.
- `busyO` out 1: high whenever the state is not IDLE.

## Operation
States: IDLE, CHECK, RD, RMWRD, RMWWR, WR, DONE, FAIL.

- **IDLE.** When `devREQI` is sampled high, latch `devADDRI`, `devDATAI`, `pageADDRI`, `pageFLGI` and `pageNXMI`, then go to CHECK.
- **CHECK.**
  - Latched NXM, or neither or both of read/write set → FAIL.
  - Read → RD.
  - Write with FTM=1 and RPW=0 → WR, with the full 36-bit word.
  - Any other write → RMWRD.
- **RD.** Assert `busREQO` with the read flag. On `busACKI`, capture `busDATAI`. If E16=1, zero bits 0,1,18,19 of the captured word. Go to DONE.
- **RMWRD.** Read as in RD, but capture into the merge register. Go to RMWWR.
- **RMWWR.** Replace the W-selected half of the merge register with the same half of `devDATAI`: W=0 replaces bits 0:17, W=1 replaces bits 18:35. If E16=1, zero the top two bits of the replaced half. Assert `busREQO` with the write flag and the merged data. On `busACKI` → DONE.
- **WR.** As in RMWWR, without the merge. If E16=1, zero bits 0,1,18,19.
- **DONE.** Pulse `devACKO` and go to IDLE.
- **FAIL.** Pulse `devNXMO` and go to IDLE. `devDATAO` keeps its previous value.
- **Bus timeout.** In RD, RMWRD, RMWWR or WR, a free-running counter clears on state entry. Reaching `TIMEOUT` without `busACKI` → FAIL, and `busREQO` drops in the same transition.
- **Address.** `busADDRO` = {flags, `pageADDRI`[14:35] latched}. Bits 0:13 are zero except the read/write flag.

## Timing
- Reset values: every output is 0, and the state is IDLE. Reset mid-transfer drops `busREQO` immediately and no pulse is emitted.
- Latency with ack in the first request cycle:
  - read: 4 cycles from the `devREQI` sample to `devACKO`.
  - FTM write: 4 cycles.
  - RMW write: 5 cycles.
- `busREQO` is registered. It rises the cycle after CHECK and falls the cycle after the `busACKI` sample.
- `busADDRO` and `busDATAO` are stable for the whole time `busREQO` is high.
- `devREQI` is ignored while `busyO`=1. A new request is accepted no earlier than the cycle after a `devACKO` or `devNXMO` pulse.
- `busACKI` sampled in IDLE, CHECK, DONE or FAIL is ignored.
- If `busACKI` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins.
- The counter is 8 bits and saturates; it never wraps.

## Structure
- `uba_dma_pkg` holds:
  - the state enum;
  - flag bit positions: READ=3, WRITE=5, W=34;
  - `pageFLGI` indices: RPW=0, E16=1, FTM=2;
  - the E16 mask constant.
- Sub-module `uba_dma_timer` holds the clear/enable/saturating counter and its `expired` output. It is parameterised by `TIMEOUT`.

## Test plan
- Read, page 5 mapped to PPN 0x123, FTM=0, bus acks on the first cycle, `busDATAI`=0o777777_777777, E16=1 → `busADDRO` read flag set, address field 0x123<<9 | word; `devDATAO`=0o177777_177777; one `devACKO`.
- Write, W=1, FTM=0, `devDATAI`[18:35]=0o123456, read-back 0o111111_222222 → second bus cycle writes 0o111111_123456; `devACKO` 5 cycles after request.
- Write, FTM=1, RPW=0 → exactly one bus write of the full `devDATAI` word; no read cycle.
- `pageNXMI`=1 → no `busREQO`; `devNXMO` pulses in cycle 3.
- Bus never acks, `TIMEOUT`=10 → `busREQO` high for exactly 10 cycles, then `devNXMO`; the next request is accepted normally.
- `rst` asserted while `busREQO` is high → all outputs 0 asynchronously; after release the block is IDLE with no pulses.

Source files
------------

// File: rtl/uba_dma_pkg.sv
// Shared types and constants for the UBA DMA bus-master sequencer.
// Bit positions use KS10 numbering (bit 0 = MSB); *_IDX give the SystemVerilog index.
package uba_dma_pkg;

    typedef enum logic [2:0] {
        IDLE, CHECK, RD, RMWRD, RMWWR, WR, DONE, FAIL
    } state_t;

    localparam int READ  = 3;
    localparam int WRITE = 5;
    localparam int W     = 34;

    localparam int READ_IDX  = 35 - READ;
    localparam int WRITE_IDX = 35 - WRITE;
    localparam int W_IDX     = 35 - W;

    localparam int RPW = 0;
    localparam int E16 = 1;
    localparam int FTM = 2;

    // Clears KS10 bits 0,1,18,19: an 18-bit device only sees 16 bits per half.
    localparam logic [35:0] E16_MASK = 36'o177777_177777;

    // Replace the W-selected half of word with the same half of dev.
    function automatic logic [35:0] mergeHalf(input logic [35:0] word,
                                              input logic [35:0] dev,
                                              input logic        w,
                                              input logic        e16);
        logic [35:0] halfSel;
        logic [35:0] newHalf;
        halfSel = w ? 36'o000000_777777 : 36'o777777_000000;
        newHalf = dev & halfSel;
        if (e16)
            newHalf = newHalf & E16_MASK;
        return (word & ~halfSel) | newHalf;
    endfunction

endpackage

// File: rtl/uba_dma_timer.sv
// Bus-cycle watchdog: 8-bit saturating counter, cleared on state entry.
// expired is high on the TIMEOUT-th cycle counted since the last clear.
module uba_dma_timer
    import uba_dma_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

    assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/uba_dma_master.sv
// NPR bus-master sequencer: one device request at a time, read / write / read-pause-write
// on the KS10 bus, with E16 masking and a bus watchdog that converts a missing ack into NXM.
module uba_dma_master
    import uba_dma_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devREQI,
    input  logic [35:0] devADDRI,
    input  logic [35:0] devDATAI,
    output logic [35:0] devDATAO,
    output logic        devACKO,
    output logic        devNXMO,
    input  logic [35:0] pageADDRI,
    input  logic        pageNXMI,
    input  logic [2:0]  pageFLGI,
    output logic        busREQO,
    input  logic        busACKI,
    output logic [35:0] busADDRO,
    output logic [35:0] busDATAO,
    input  logic [35:0] busDATAI,
    output logic        busyO
);

    state_t      state, nextState;
    logic        rdQ, wrQ, wQ, nxmQ;
    logic [2:0]  flgQ;
    logic [35:0] dataQ;
    logic [21:0] pageQ;
    logic        busState, nextBus, expired;
    logic [35:0] nextAddr;
    logic        unusedBits;

    assign unusedBits = ^{devADDRI[35:33], devADDRI[31], devADDRI[29:2], devADDRI[0],
                          pageADDRI[35:22]};

    assign busState = (state inside {RD, RMWRD, RMWWR, WR});
    assign nextBus  = (nextState inside {RD, RMWRD, RMWWR, WR});

    uba_dma_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (nextState != state),
        .en      (busState),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (devREQI) nextState = CHECK;
            CHECK: begin
                if (nxmQ || (rdQ == wrQ))         nextState = FAIL;
                else if (rdQ)                     nextState = RD;
                else if (flgQ[FTM] && !flgQ[RPW]) nextState = WR;
                else                              nextState = RMWRD;
            end
            RD, RMWWR, WR: begin
                if (busACKI)      nextState = DONE;
                else if (expired) nextState = FAIL;
            end
            RMWRD: begin
                if (busACKI)      nextState = RMWWR;
                else if (expired) nextState = FAIL;
            end
            DONE, FAIL: nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    always_comb begin
        devACKO = (state == DONE);
        devNXMO = (state == FAIL);
        busyO   = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdQ   <= 1'b0;
            wrQ   <= 1'b0;
            wQ    <= 1'b0;
            nxmQ  <= 1'b0;
            flgQ  <= 3'd0;
            dataQ <= 36'd0;
            pageQ <= 22'd0;
        end else if (state == IDLE && devREQI) begin
            rdQ   <= devADDRI[READ_IDX];
            wrQ   <= devADDRI[WRITE_IDX];
            wQ    <= devADDRI[W_IDX];
            nxmQ  <= pageNXMI;
            flgQ  <= pageFLGI;
            dataQ <= devDATAI;
            pageQ <= pageADDRI[21:0];
        end
    end

    always_comb begin
        nextAddr            = {14'd0, pageQ};
        nextAddr[READ_IDX]  = (nextState inside {RD, RMWRD});
        nextAddr[WRITE_IDX] = (nextState inside {RMWWR, WR});
    end

    // Address and data load only on entry to a bus state, so they hold for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busREQO  <= 1'b0;
            busADDRO <= 36'd0;
            busDATAO <= 36'd0;
            devDATAO <= 36'd0;
        end else begin
            busREQO <= nextBus;
            if (nextBus && nextState != state)
                busADDRO <= nextAddr;
            if (state == CHECK && nextState == WR)
                busDATAO <= flgQ[E16] ? (dataQ & E16_MASK) : dataQ;
            if (state == RMWRD && nextState == RMWWR)
                busDATAO <= mergeHalf(busDATAI, dataQ, wQ, flgQ[E16]);
            if (state == RD && busACKI)
                devDATAO <= flgQ[E16] ? (busDATAI & E16_MASK) : busDATAI;
        end
    end

endmodule

// File: tb/tb_uba_dma_master.sv
// Bench for uba_dma_master: directed vector table, reset corner, then random transactions
// whose expectations come from a transaction-level model of the sequencing rules.
module tb_uba_dma_master;

    localparam int T = 10;
    localparam logic [35:0] A_RD = 36'h1_0000_0000;
    localparam logic [35:0] A_WR = 36'h0_4000_0000;
    localparam logic [35:0] A_W  = 36'h0_0000_0002;
    localparam logic [35:0] PG5  = 36'h0_0000_2800;
    localparam logic [35:0] PA   = 36'h0_0002_4607;

    logic        clk = 1'b0;
    logic        rst;
    logic        devREQI, devACKO, devNXMO, pageNXMI, busREQO, busACKI, busyO;
    logic [35:0] devADDRI, devDATAI, devDATAO, pageADDRI, busADDRO, busDATAO, busDATAI;
    logic [2:0]  pageFLGI;

    int checks   = 0;
    int failures = 0;
    logic [35:0] prevDev;

    always #5 clk = ~clk;

    uba_dma_master #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .devREQI(devREQI), .devADDRI(devADDRI), .devDATAI(devDATAI), .devDATAO(devDATAO),
        .devACKO(devACKO), .devNXMO(devNXMO),
        .pageADDRI(pageADDRI), .pageNXMI(pageNXMI), .pageFLGI(pageFLGI),
        .busREQO(busREQO), .busACKI(busACKI), .busADDRO(busADDRO), .busDATAO(busDATAO),
        .busDATAI(busDATAI), .busyO(busyO)
    );

    typedef struct {
        logic [35:0] addr, data, page;
        logic [2:0]  flg;
        logic        nxm;
        logic [35:0] rdata;
        int          d1, d2;
        logic        expAck;
        int          expCyc, expPhases, expReqCyc;
        logic [35:0] expDev, expWr;
    } vec_t;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0o required=%0o", name, act, exp);
        end
    endtask

    function automatic logic [35:0] r36();
        return {4'($urandom), $urandom};
    endfunction

    function automatic vec_t mk(logic [35:0] addr, logic [35:0] data, logic [35:0] page,
                                logic [2:0] flg, logic nxm, logic [35:0] rdata, int d1, int d2,
                                logic expAck, int expCyc, int expPhases, int expReqCyc,
                                logic [35:0] expDev, logic [35:0] expWr);
        vec_t v;
        v.addr = addr; v.data = data; v.page = page; v.flg = flg; v.nxm = nxm;
        v.rdata = rdata; v.d1 = d1; v.d2 = d2; v.expAck = expAck; v.expCyc = expCyc;
        v.expPhases = expPhases; v.expReqCyc = expReqCyc; v.expDev = expDev; v.expWr = expWr;
        return v;
    endfunction

    function automatic logic [35:0] strip16(logic [35:0] x);
        return {2'b00, x[33:18], 2'b00, x[15:0]};
    endfunction

    // Transaction-level reference: outcome, bus phases, cycle counts, data.
    function automatic vec_t model(vec_t v, logic [35:0] prev);
        logic rd, wr, e16, ok1, ok2;
        logic [17:0] hi, lo;
        int len1, len2;
        rd = v.addr[32]; wr = v.addr[30]; e16 = v.flg[1];
        v.expDev = prev; v.expWr = '0; v.expPhases = 0; v.expReqCyc = 0; v.expAck = 1'b0;
        v.expCyc = 2;
        if (v.nxm || rd == wr) return v;
        ok1  = (v.d1 + 1 <= T);
        len1 = ok1 ? v.d1 + 1 : T;
        v.expPhases = 1; v.expReqCyc = len1; v.expAck = ok1;
        if (rd) begin
            if (ok1) v.expDev = e16 ? strip16(v.rdata) : v.rdata;
        end else if (v.flg[2] && !v.flg[0]) begin
            v.expWr = e16 ? strip16(v.data) : v.data;
        end else if (ok1) begin
            ok2  = (v.d2 + 1 <= T);
            len2 = ok2 ? v.d2 + 1 : T;
            v.expPhases = 2; v.expReqCyc = len1 + len2; v.expAck = ok2;
            hi = v.rdata[35:18]; lo = v.rdata[17:0];
            if (v.addr[1]) begin
                lo = v.data[17:0];
                if (e16) lo[17:16] = 2'b00;
            end else begin
                hi = v.data[35:18];
                if (e16) hi[17:16] = 2'b00;
            end
            v.expWr = {hi, lo};
        end
        v.expCyc = 2 + v.expReqCyc;
        return v;
    endfunction

    task automatic runTxn(input vec_t v, input int idx);
        int cyc, phaseIdx, phaseCnt, reqCyc, dly;
        logic prevReq, done, gotAck, isRead;
        logic [35:0] curAddr, curData, expA;
        cyc = 0; phaseIdx = 0; phaseCnt = 0; reqCyc = 0; prevReq = 1'b0; done = 1'b0;
        gotAck = 1'b0; curAddr = '0; curData = '0;
        @(negedge clk);
        devREQI = 1'b1; devADDRI = v.addr; devDATAI = v.data; pageADDRI = v.page;
        pageFLGI = v.flg; pageNXMI = v.nxm; busACKI = 1'b0;
        @(posedge clk);
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            devADDRI = r36(); devDATAI = r36(); pageADDRI = r36();
            pageFLGI = 3'($urandom); pageNXMI = 1'($urandom);
            if (devACKO || devNXMO) begin
                done = 1'b1; gotAck = devACKO;
                devREQI = 1'b0; busACKI = 1'b0;
                check($sformatf("v%0d pulse", idx), {35'd0, gotAck}, {35'd0, v.expAck});
                check($sformatf("v%0d both-pulses", idx), {35'd0, devACKO & devNXMO}, 36'd0);
                check($sformatf("v%0d latency", idx), 36'(cyc), 36'(v.expCyc));
                check($sformatf("v%0d phases", idx), 36'(phaseIdx), 36'(v.expPhases));
                check($sformatf("v%0d req-cycles", idx), 36'(reqCyc), 36'(v.expReqCyc));
                check($sformatf("v%0d devDATAO", idx), devDATAO, v.expDev);
            end else if (busREQO) begin
                if (!prevReq || busADDRO !== curAddr) begin
                    phaseIdx++; phaseCnt = 0; curAddr = busADDRO; curData = busDATAO;
                    isRead = (phaseIdx == 1) && (v.addr[32] || !(v.flg[2] && !v.flg[0]));
                    expA = {14'd0, v.page[21:0]};
                    if (isRead) expA[32] = 1'b1; else expA[30] = 1'b1;
                    check($sformatf("v%0d busADDRO p%0d", idx, phaseIdx), busADDRO, expA);
                    if (!isRead)
                        check($sformatf("v%0d busDATAO", idx), busDATAO, v.expWr);
                end else begin
                    check($sformatf("v%0d addr-stable", idx), busADDRO, curAddr);
                    if (curAddr[30])
                        check($sformatf("v%0d data-stable", idx), busDATAO, curData);
                end
                reqCyc++; phaseCnt++;
                dly = (phaseIdx == 1) ? v.d1 : v.d2;
                busACKI  = (phaseCnt > dly);
                busDATAI = busACKI ? v.rdata : r36();
            end else begin
                busACKI = 1'($urandom); busDATAI = r36();
            end
            prevReq = busREQO;
        end
        if (!done) begin
            check($sformatf("v%0d no-completion", idx), 36'd0, 36'd1);
            devREQI = 1'b0;
        end
        @(negedge clk);
        busACKI = 1'b0;
        check($sformatf("v%0d idle-after", idx), {34'd0, busyO, devACKO | devNXMO}, 36'd0);
    endtask

    vec_t tbl[13];
    vec_t v;

    initial begin
        rst = 1'b1; devREQI = 1'b0; devADDRI = '0; devDATAI = '0; pageADDRI = '0;
        pageFLGI = '0; pageNXMI = 1'b0; busACKI = 1'b0; busDATAI = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset-outputs", {devDATAO ^ busADDRO ^ busDATAO}, 36'd0);
        check("reset-ctrl", {32'd0, devACKO, devNXMO, busREQO, busyO}, 36'd0);
        @(negedge clk); rst = 1'b0;

        tbl[0]  = mk(A_RD | PG5, '0, PA, 3'b010, 0, 36'o777777_777777, 0, 0,
                     1, 3, 1, 1, 36'o177777_177777, '0);
        tbl[1]  = mk(A_WR | A_W | PG5, 36'o555555_123456, PA, 3'b000, 0, 36'o111111_222222, 0, 0,
                     1, 4, 2, 2, 36'o177777_177777, 36'o111111_123456);
        tbl[2]  = mk(A_WR, 36'o123456_654321, PA, 3'b100, 0, 36'o7, 0, 0,
                     1, 3, 1, 1, 36'o177777_177777, 36'o123456_654321);
        tbl[3]  = mk(A_RD, '0, PA, 3'b000, 1, 36'o7, 0, 0,
                     0, 2, 0, 0, 36'o177777_177777, '0);
        tbl[4]  = mk(A_RD, '0, PA, 3'b000, 0, 36'o7, 255, 0,
                     0, 12, 1, 10, 36'o177777_177777, '0);
        tbl[5]  = mk(A_RD, '0, 36'hF_FFC0_1234, 3'b000, 0, 36'o123456_701234, 2, 0,
                     1, 5, 1, 3, 36'o123456_701234, '0);
        tbl[6]  = mk(A_RD | A_WR, '0, PA, 3'b000, 0, 36'o7, 0, 0,
                     0, 2, 0, 0, 36'o123456_701234, '0);
        tbl[7]  = mk(36'o0, '0, PA, 3'b000, 0, 36'o7, 0, 0,
                     0, 2, 0, 0, 36'o123456_701234, '0);
        tbl[8]  = mk(A_WR, 36'o777777_000000, PA, 3'b010, 0, 36'o222222_333333, 0, 0,
                     1, 4, 2, 2, 36'o123456_701234, 36'o177777_333333);
        tbl[9]  = mk(A_WR, 36'o444444_555555, PA, 3'b101, 0, 36'o666666_777777, 1, 3,
                     1, 8, 2, 6, 36'o123456_701234, 36'o444444_777777);
        tbl[10] = mk(A_WR, 36'o777777_777777, PA, 3'b110, 0, 36'o7, 0, 0,
                     1, 3, 1, 1, 36'o123456_701234, 36'o177777_177777);
        tbl[11] = mk(A_RD, '0, PA, 3'b000, 0, 36'o1, 9, 0,
                     1, 12, 1, 10, 36'o1, '0);
        tbl[12] = mk(A_RD, '0, PA, 3'b000, 0, 36'o7, 10, 0,
                     0, 12, 1, 10, 36'o1, '0);
        for (int i = 0; i < 13; i++)
            runTxn(tbl[i], i);

        // Reset while the bus request is outstanding.
        @(negedge clk);
        devREQI = 1'b1; devADDRI = A_RD; pageADDRI = PA; pageFLGI = 3'b000; pageNXMI = 1'b0;
        busACKI = 1'b0;
        for (int i = 0; i < 20 && !busREQO; i++) @(negedge clk);
        check("rst-req-seen", {35'd0, busREQO}, 36'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst-async-data", devDATAO | busADDRO | busDATAO, 36'd0);
        check("rst-async-ctrl", {32'd0, devACKO, devNXMO, busREQO, busyO}, 36'd0);
        devREQI = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst-quiet%0d", i), {33'd0, devACKO, devNXMO, busyO | busREQO}, 36'd0);
        end
        prevDev = '0;

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 9);
            v.addr = r36();
            v.addr[32] = (op < 4) || (op == 8);
            v.addr[30] = (op >= 4);
            if (op == 9) v.addr[32] = 1'b0;
            if (op == 9) v.addr[30] = 1'b0;
            v.data = r36(); v.page = r36(); v.flg = 3'($urandom); v.rdata = r36();
            v.nxm = ($urandom_range(0, 7) == 0);
            v.d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3);
            v.d2 = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3);
            v = model(v, prevDev);
            runTxn(v, 100 + i);
            prevDev = v.expDev;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
